// File: rtl/peripheral_gpio_apb4.sv
// rtl/peripheral_gpio_apb4.sv - APB4 GPIO peripheral with wait states, byte strobes and pin interrupts
module peripheral_gpio_apb4 #(
    parameter int PADDR_SIZE  = 4,
    parameter int PDATA_SIZE  = 8,
    parameter int SYNC_DEPTH  = 2,
    parameter int WAIT_STATES = 0
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    input  logic [PDATA_SIZE-1:0]   gpio_i,
    output logic [PDATA_SIZE-1:0]   gpio_o,
    output logic [PDATA_SIZE-1:0]   gpio_oe,
    output logic                    irq_o
);

    localparam int         NUM_BYTES = PDATA_SIZE / 8;
    localparam int         IDX_SHIFT = $clog2(NUM_BYTES);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES);

    localparam logic [2:0] IDX_DIR       = 3'd0;
    localparam logic [2:0] IDX_OUT       = 3'd1;
    localparam logic [2:0] IDX_IN        = 3'd2;
    localparam logic [2:0] IDX_TRIG_TYPE = 3'd3;
    localparam logic [2:0] IDX_TRIG_LVL0 = 3'd4;
    localparam logic [2:0] IDX_TRIG_LVL1 = 3'd5;
    localparam logic [2:0] IDX_IRQ_ENA   = 3'd6;
    localparam logic [2:0] IDX_STATUS    = 3'd7;

    logic                  access;
    logic [PADDR_SIZE-1:0] idx;
    logic [2:0]            sel;
    logic                  mapped;
    logic                  wr_en;
    logic [3:0]            wait_cnt;
    logic [PDATA_SIZE-1:0] wmask;

    logic [PDATA_SIZE-1:0] dir_q;
    logic [PDATA_SIZE-1:0] out_q;
    logic [PDATA_SIZE-1:0] trig_type_q;
    logic [PDATA_SIZE-1:0] trig_lvl0_q;
    logic [PDATA_SIZE-1:0] trig_lvl1_q;
    logic [PDATA_SIZE-1:0] irq_ena_q;
    logic [PDATA_SIZE-1:0] status_q;

    logic [PDATA_SIZE-1:0] sync_q [SYNC_DEPTH];
    logic [PDATA_SIZE-1:0] in_q;
    logic [PDATA_SIZE-1:0] in_d_q;

    logic [PDATA_SIZE-1:0] level_hit;
    logic [PDATA_SIZE-1:0] edge_hit;
    logic [PDATA_SIZE-1:0] trigger;
    logic [PDATA_SIZE-1:0] clear_mask;
    logic [PDATA_SIZE-1:0] rdata_mux;

    // Address decode: word index, mapped range and the low bits that select a register
    assign access = PSEL & PENABLE;
    assign idx    = PADDR >> IDX_SHIFT;
    assign mapped = (idx < PADDR_SIZE'(8));
    assign sel    = idx[2:0];

    // Handshake: PREADY once the access phase has lasted WAIT_STATES extra cycles
    assign PREADY  = access & (wait_cnt == WAIT_LAST);
    assign PSLVERR = PREADY & ~mapped;
    assign wr_en   = PREADY & PWRITE & mapped;

    // Access-cycle counter; anything other than an access phase (setup, idle, dropped PSEL) restarts it
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            wait_cnt <= '0;
        end else if (!access) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LAST) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

    // Expand byte strobes into a per-bit write mask
    always_comb begin
        wmask = '0;
        for (int b = 0; b < NUM_BYTES; b++) begin
            wmask[b*8 +: 8] = {8{PSTRB[b]}};
        end
    end

    function automatic logic [PDATA_SIZE-1:0] merge(input logic [PDATA_SIZE-1:0] old_val,
                                                    input logic [PDATA_SIZE-1:0] new_val,
                                                    input logic [PDATA_SIZE-1:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

    // Read/write configuration registers; IN and STATUS are handled elsewhere
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            dir_q       <= '0;
            out_q       <= '0;
            trig_type_q <= '0;
            trig_lvl0_q <= '0;
            trig_lvl1_q <= '0;
            irq_ena_q   <= '0;
        end else if (wr_en) begin
            case (sel)
                IDX_DIR:       dir_q       <= merge(dir_q, PWDATA, wmask);
                IDX_OUT:       out_q       <= merge(out_q, PWDATA, wmask);
                IDX_TRIG_TYPE: trig_type_q <= merge(trig_type_q, PWDATA, wmask);
                IDX_TRIG_LVL0: trig_lvl0_q <= merge(trig_lvl0_q, PWDATA, wmask);
                IDX_TRIG_LVL1: trig_lvl1_q <= merge(trig_lvl1_q, PWDATA, wmask);
                IDX_IRQ_ENA:   irq_ena_q   <= merge(irq_ena_q, PWDATA, wmask);
                default: ;
            endcase
        end
    end

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;

    // Input synchroniser chain plus one extra stage holding the previous IN for edge detection
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < SYNC_DEPTH; i++) begin
                sync_q[i] <= '0;
            end
            in_d_q <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC_DEPTH; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            in_d_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign in_q = sync_q[SYNC_DEPTH-1];

    // Per-pin trigger: level or edge selected by TRIG_TYPE; LVL0 and LVL1 together give any-edge
    always_comb begin
        level_hit = (trig_lvl1_q & in_q) | (trig_lvl0_q & ~in_q);
        edge_hit  = (trig_lvl1_q & in_q & ~in_d_q) | (trig_lvl0_q & ~in_q & in_d_q);
        trigger   = (trig_type_q & edge_hit) | (~trig_type_q & level_hit);
    end

    assign clear_mask = (wr_en && sel == IDX_STATUS) ? (PWDATA & wmask) : '0;

    // Sticky status: W1C clears, but a trigger in the same cycle keeps the bit set
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~clear_mask) | trigger;
        end
    end

    // Interrupt line follows enabled status one cycle later
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= |(status_q & irq_ena_q);
        end
    end

    // Read mux: only drives data during a mapped access phase
    always_comb begin
        rdata_mux = '0;
        if (access && mapped) begin
            case (sel)
                IDX_DIR:       rdata_mux = dir_q;
                IDX_OUT:       rdata_mux = out_q;
                IDX_IN:        rdata_mux = in_q;
                IDX_TRIG_TYPE: rdata_mux = trig_type_q;
                IDX_TRIG_LVL0: rdata_mux = trig_lvl0_q;
                IDX_TRIG_LVL1: rdata_mux = trig_lvl1_q;
                IDX_IRQ_ENA:   rdata_mux = irq_ena_q;
                IDX_STATUS:    rdata_mux = status_q;
                default:       rdata_mux = '0;
            endcase
        end
    end

    assign PRDATA = rdata_mux;

endmodule

// File: tb/tb_peripheral_gpio_apb4.sv
// tb/tb_peripheral_gpio_apb4.sv - self-checking bench for peripheral_gpio_apb4
module tb_peripheral_gpio_apb4;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int SD = 2;
    localparam int WS = 3;

    logic          PCLK;
    logic          PRESET;
    logic          PSEL;
    logic          PENABLE;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic [3:0]    PSTRB;
    logic [DW-1:0] PWDATA;
    logic [DW-1:0] PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic [DW-1:0] gpio_i;
    logic [DW-1:0] gpio_o;
    logic [DW-1:0] gpio_oe;
    logic          irq_o;

    int checks = 0;
    int errors = 0;

    peripheral_gpio_apb4 #(
        .PADDR_SIZE (AW),
        .PDATA_SIZE (DW),
        .SYNC_DEPTH (SD),
        .WAIT_STATES(WS)
    ) dut (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .PSEL   (PSEL),
        .PENABLE(PENABLE),
        .PADDR  (PADDR),
        .PWRITE (PWRITE),
        .PSTRB  (PSTRB),
        .PWDATA (PWDATA),
        .PRDATA (PRDATA),
        .PREADY (PREADY),
        .PSLVERR(PSLVERR),
        .gpio_i (gpio_i),
        .gpio_o (gpio_o),
        .gpio_oe(gpio_oe),
        .irq_o  (irq_o)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Behavioural model: register file by index, pin sample history, access-cycle count
    logic [31:0] m_reg [8];
    logic [31:0] smp [$];
    int          m_acc;
    logic        m_irq;
    bit          live = 0;
    logic [31:0] m_in, m_ind, m_lvl, m_edg, m_trig, m_clr, m_wm;
    int          m_idx;
    bit          m_rdy;

    function automatic logic exp_ready();
        return PSEL && PENABLE && (m_acc == WS);
    endfunction

    function automatic logic [31:0] exp_rdata();
        int i = int'(PADDR) / 4;
        if (!(PSEL && PENABLE) || i > 7) return 32'h0;
        if (i == 2) return smp[1];
        return m_reg[i];
    endfunction

    always @(posedge PCLK) begin
        if (PRESET) begin
            for (int i = 0; i < 8; i++) m_reg[i] = 32'h0;
            smp.delete();
            for (int i = 0; i < SD + 1; i++) smp.push_back(32'h0);
            m_acc = 0;
            m_irq = 1'b0;
            live  = 1;
        end else if (live) begin
            // smp[1] is the synchronised IN, smp[0] the value one cycle before
            m_in   = smp[1];
            m_ind  = smp[0];
            m_idx  = int'(PADDR) / 4;
            m_rdy  = exp_ready();
            m_lvl  = (m_reg[5] & m_in) | (m_reg[4] & ~m_in);
            m_edg  = (m_reg[5] & m_in & ~m_ind) | (m_reg[4] & ~m_in & m_ind);
            m_trig = (m_reg[3] & m_edg) | (~m_reg[3] & m_lvl);
            m_irq  = |(m_reg[7] & m_reg[6]);
            for (int b = 0; b < 4; b++) m_wm[b*8 +: 8] = PSTRB[b] ? 8'hFF : 8'h00;
            m_clr = 32'h0;
            if (m_rdy && PWRITE && m_idx < 8) begin
                if (m_idx == 7) m_clr = PWDATA & m_wm;
                else if (m_idx != 2) m_reg[m_idx] = (m_reg[m_idx] & ~m_wm) | (PWDATA & m_wm);
            end
            m_reg[7] = (m_reg[7] & ~m_clr) | m_trig;
            if (!(PSEL && PENABLE)) m_acc = 0;
            else if (m_acc < WS) m_acc++;
            smp.push_back(gpio_i);
            void'(smp.pop_front());
        end
    end

    // Every-cycle comparison against the model, just after the edge
    always @(posedge PCLK) begin
        #1;
        if (live) begin
            chk("cyc_prdata",  PRDATA, exp_rdata());
            chk("cyc_pready",  {31'b0, PREADY}, {31'b0, exp_ready()});
            chk("cyc_pslverr", {31'b0, PSLVERR}, {31'b0, exp_ready() && (int'(PADDR) / 4 > 7)});
            chk("cyc_gpio_o",  gpio_o, m_reg[1]);
            chk("cyc_gpio_oe", gpio_oe, m_reg[0]);
            chk("cyc_irq",     {31'b0, irq_o}, {31'b0, m_irq});
        end
    end

    // One APB transfer; returns at the negedge where PREADY is seen, leaving PSEL up
    task automatic apb(input logic [AW-1:0] a, input logic w, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rd, output logic err,
                       output int nacc);
        bit done = 0;
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = w; PWDATA = d; PSTRB = s;
        @(negedge PCLK);
        PENABLE = 1'b1;
        nacc = 0;
        rd = 32'h0;
        err = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            nacc++;
            #1;
            if (PREADY) begin
                rd = PRDATA;
                err = PSLVERR;
                done = 1;
            end else begin
                @(negedge PCLK);
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL apb_timeout addr %h no PREADY within 20 access cycles", a);
        end
    endtask

    task automatic end_xfer();
        @(negedge PCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic idle(input int n);
        end_xfer();
        repeat (n) @(negedge PCLK);
    endtask

    task automatic wr(input int i, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        logic e;
        int n;
        apb(AW'(i * 4), 1'b1, d, s, r, e, n);
    endtask

    task automatic rd_chk(input string name, input int i, input logic [31:0] exp);
        logic [31:0] r;
        logic e;
        int n;
        apb(AW'(i * 4), 1'b0, 32'h0, 4'h0, r, e, n);
        chk(name, r, exp);
        chk({name, "_slverr"}, {31'b0, e}, (i > 7) ? 32'd1 : 32'd0);
    endtask

    initial begin
        logic [31:0] r;
        logic e;
        int n;

        PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
        PSTRB = 4'h0; PWDATA = 32'h0; gpio_i = 32'h0;

        // Reset and readback of the whole map, back to back
        repeat (2) @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        chk("rst_gpio_oe", gpio_oe, 32'h0);
        chk("rst_gpio_o", gpio_o, 32'h0);
        chk("rst_irq", {31'b0, irq_o}, 32'h0);
        chk("rst_pready", {31'b0, PREADY}, 32'h0);
        for (int i = 0; i < 8; i++) rd_chk("rst_read", i, 32'h0);
        idle(1);

        // Byte strobes
        wr(0, 32'hA5A5_A5A5, 4'b0101);
        end_xfer();
        #1;
        chk("strb_gpio_oe", gpio_oe, 32'h00A5_00A5);
        rd_chk("strb_dir", 0, 32'h00A5_00A5);
        wr(1, 32'h1234_5678, 4'b1000);
        end_xfer();
        #1;
        chk("strb_gpio_o", gpio_o, 32'h1200_0000);

        // Wait states, unmapped read/write, IN readback
        apb(AW'(36), 1'b0, 32'h0, 4'h0, r, e, n);
        chk("ws_access_cycles", n, 32'd4);
        chk("unmapped_rdata", r, 32'h0);
        chk("unmapped_slverr", {31'b0, e}, 32'd1);
        apb(AW'(36), 1'b1, 32'hFFFF_FFFF, 4'hF, r, e, n);
        chk("unmapped_wr_slverr", {31'b0, e}, 32'd1);
        rd_chk("unmapped_wr_out", 1, 32'h1200_0000);
        rd_chk("unmapped_wr_dir", 0, 32'h00A5_00A5);
        idle(1);
        gpio_i = 32'h5A5A_0F0C;
        idle(3);
        rd_chk("in_readback", 2, 32'h5A5A_0F0C);

        // Rising-edge interrupt on pin 0
        wr(3, 32'h1, 4'hF);
        wr(5, 32'h1, 4'hF);
        wr(6, 32'h1, 4'hF);
        idle(2);
        gpio_i[0] = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        chk("edge_irq_not_yet", {31'b0, irq_o}, 32'd0);
        @(posedge PCLK);
        #1;
        chk("edge_irq_set", {31'b0, irq_o}, 32'd1);
        rd_chk("edge_status", 7, 32'h1);
        wr(7, 32'h1, 4'hF);
        end_xfer();
        #1;
        chk("w1c_irq_still", {31'b0, irq_o}, 32'd1);
        @(posedge PCLK);
        #1;
        chk("w1c_irq_fell", {31'b0, irq_o}, 32'd0);
        rd_chk("w1c_status", 7, 32'h0);

        // W1C colliding with a new rising edge: set wins
        gpio_i[0] = 1'b0;
        idle(5);
        gpio_i[0] = 1'b1;
        idle(5);
        gpio_i[0] = 1'b0;
        idle(5);
        rd_chk("pre_collide_status", 7, 32'h1);
        fork
            wr(7, 32'h1, 4'hF);
            begin
                repeat (3) @(negedge PCLK);
                gpio_i[0] = 1'b1;
            end
        join
        idle(3);
        rd_chk("collide_status", 7, 32'h1);

        // Level-low trigger on pin 1 re-sets through W1C
        wr(5, 32'h0, 4'hF);
        wr(3, 32'h0, 4'hF);
        wr(4, 32'h2, 4'hF);
        idle(2);
        wr(7, 32'hFFFF_FFFF, 4'h0);
        rd_chk("level_nostrb_status", 7, 32'h3);
        wr(7, 32'h3, 4'hF);
        idle(2);
        rd_chk("level_w1c_status", 7, 32'h2);
        idle(1);

        // Reset in the middle of a waited write to OUT
        @(negedge PCLK);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = AW'(4); PWRITE = 1'b1; PWDATA = 32'hFF; PSTRB = 4'hF;
        @(negedge PCLK);
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b1;
        @(negedge PCLK);
        #1;
        chk("midrst_pready", {31'b0, PREADY}, 32'd0);
        chk("midrst_gpio_o", gpio_o, 32'h0);
        chk("midrst_irq", {31'b0, irq_o}, 32'd0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        PRESET = 1'b0;
        idle(2);
        rd_chk("midrst_out", 1, 32'h0);
        rd_chk("midrst_dir", 0, 32'h0);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
